lcd_scheduler: RTL and testbench

Screen-buffer scheduler that sits between game/UI logic and the LCD character controller.
- Holds a 2x16 character shadow buffer with one dirty bit per cell.
- Game logic writes cells in one cycle.
- The scheduler drains dirty cells to the LCD controller, one command/response handshake per cell, in round-robin order.
- Callers never wait on the slow LCD.

---
 rtl/lcd_sched_pkg.sv | 20 ++
 rtl/lcd_rr_picker.sv | 26 ++
 rtl/lcd_scheduler.sv | 158 +++++++++++++++
 tb/tb_lcd_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_sched_pkg.sv
// Shared types and constants for the LCD screen-buffer scheduler.
// Cells are indexed {row, column}, giving 0..31 across the two 16-column rows.
package lcd_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_e;

  localparam int          LCD_COLS    = 16;
  localparam int          LCD_ROWS    = 2;
  localparam int          LCD_CELLS   = LCD_COLS * LCD_ROWS;
  localparam logic [7:0]  ASCII_SPACE = 8'h20;

  function automatic logic [4:0] cell_idx(input logic y, input logic [3:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/lcd_rr_picker.sv
// Combinational round-robin picker: first set bit of dirty_i at or after rr_ptr_i,
// wrapping modulo 32. Rotate down by the pointer, find the lowest set bit, add the pointer back.
module lcd_rr_picker
  import lcd_sched_pkg::*;
(
  input  logic [31:0] dirty_i,
  input  logic [4:0]  rr_ptr_i,
  output logic        any_dirty_o,
  output logic [4:0]  idx_o
);

  logic [31:0] rot;
  logic [4:0]  off;

  always_comb begin
    rot = 32'({dirty_i, dirty_i} >> rr_ptr_i);
    off = '0;
    for (int i = LCD_CELLS - 1; i >= 0; i--) begin
      if (rot[i]) off = i[4:0];
    end
  end

  assign any_dirty_o = |dirty_i;
  assign idx_o       = rr_ptr_i + off;

endmodule

// File: rtl/lcd_scheduler.sv
// Shadow 2x16 character buffer with per-cell dirty bits, drained one cell at a
// time to the LCD controller over a four-phase command/response handshake.
module lcd_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 21
) (
  input  logic       clock_12_5m,
  input  logic       reset_12_5m_n,
  input  logic       wr_en,
  input  logic [3:0] wr_x,
  input  logic       wr_y,
  input  logic [7:0] wr_ascii,
  input  logic       clear_req,
  output logic       busy,
  output logic       timeout_error,
  output logic       lcd_command,
  output logic [3:0] lcd_x,
  output logic       lcd_y,
  output logic [7:0] lcd_ascii,
  input  logic       lcd_response,
  output logic [1:0] dbg_state
);

  // Handshake: lcd_command rises with lcd_x/lcd_y/lcd_ascii valid and holds until
  // lcd_response is 1; the fields then stay put until lcd_response returns to 0.

  state_e           state_q, state_d;
  logic [31:0]      dirty_q, dirty_d;
  logic [4:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_q, cmd_d;
  logic [3:0]       x_q, x_d;
  logic             y_q, y_d;
  logic [7:0]       ascii_q, ascii_d;
  logic             terr_q, terr_d;
  logic [7:0]       buf_q [LCD_CELLS];

  logic             any_dirty;
  logic [4:0]       pick_idx;
  logic [4:0]       wr_idx;
  logic [4:0]       cur_idx;
  logic             timeout;

  lcd_rr_picker u_picker (
    .dirty_i     (dirty_q),
    .rr_ptr_i    (rr_ptr_q),
    .any_dirty_o (any_dirty),
    .idx_o       (pick_idx)
  );

  assign wr_idx  = cell_idx(wr_y, wr_x);
  assign cur_idx = cell_idx(y_q, x_q);
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    dirty_d  = dirty_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q + CNT_W'(1);
    cmd_d    = cmd_q;
    x_d      = x_q;
    y_d      = y_q;
    ascii_d  = ascii_q;
    terr_d   = terr_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Never raise a new command while the controller is still acknowledging.
        if (any_dirty && !lcd_response) begin
          x_d               = pick_idx[3:0];
          y_d               = pick_idx[4];
          ascii_d           = buf_q[pick_idx];
          dirty_d[pick_idx] = 1'b0;
          rr_ptr_d          = pick_idx + 5'd1;
          cmd_d             = 1'b1;
          state_d           = ST_REQ;
        end
      end
      ST_REQ: begin
        if (lcd_response) begin
          cmd_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_REL;
        end else if (timeout) begin
          terr_d           = 1'b1;
          cmd_d            = 1'b0;
          dirty_d[cur_idx] = 1'b1;
          cnt_d            = '0;
          state_d          = ST_REL;
        end
      end
      ST_REL: begin
        if (!lcd_response || timeout) begin
          if (lcd_response) terr_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Caller updates override a launch-time clear so the newer data is re-sent.
    if (clear_req) begin
      dirty_d = '1;
    end else if (wr_en) begin
      dirty_d[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock_12_5m or negedge reset_12_5m_n) begin
    if (!reset_12_5m_n) begin
      state_q  <= ST_IDLE;
      dirty_q  <= '1;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      cmd_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= 1'b0;
      ascii_q  <= ASCII_SPACE;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dirty_q  <= dirty_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ascii_q  <= ascii_d;
      terr_q   <= terr_d;
    end
  end

  always_ff @(posedge clock_12_5m or negedge reset_12_5m_n) begin
    if (!reset_12_5m_n) begin
      for (int i = 0; i < LCD_CELLS; i++) buf_q[i] <= ASCII_SPACE;
    end else if (clear_req) begin
      for (int i = 0; i < LCD_CELLS; i++) buf_q[i] <= ASCII_SPACE;
    end else if (wr_en) begin
      buf_q[wr_idx] <= wr_ascii;
    end
  end

  assign busy          = (state_q != ST_IDLE) | (|dirty_q);
  assign timeout_error = terr_q;
  assign lcd_command   = cmd_q;
  assign lcd_x         = x_q;
  assign lcd_y         = y_q;
  assign lcd_ascii     = ascii_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_lcd_scheduler.sv
// Directed bench for lcd_scheduler: LCD responder model, handshake monitor with
// an expected-cell queue, a table of single-cell writes and multi-cycle sequences.
module tb_lcd_scheduler;
  import lcd_sched_pkg::*;

  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_x = '0;
  logic       wr_y = 1'b0;
  logic [7:0] wr_ascii = '0;
  logic       clear_req = 1'b0;
  logic       busy;
  logic       timeout_error;
  logic       lcd_command;
  logic [3:0] lcd_x;
  logic       lcd_y;
  logic [7:0] lcd_ascii;
  logic       lcd_response;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [12:0] exp_q[$];

  always #5 clk = ~clk;

  lcd_scheduler #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clock_12_5m   (clk),
    .reset_12_5m_n (rst_n),
    .wr_en         (wr_en),
    .wr_x          (wr_x),
    .wr_y          (wr_y),
    .wr_ascii      (wr_ascii),
    .clear_req     (clear_req),
    .busy          (busy),
    .timeout_error (timeout_error),
    .lcd_command   (lcd_command),
    .lcd_x         (lcd_x),
    .lcd_y         (lcd_y),
    .lcd_ascii     (lcd_ascii),
    .lcd_response  (lcd_response),
    .dbg_state     (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // LCD model: ack 20 cycles after command rises, release 5 cycles after it falls.
  logic no_ack = 1'b0;
  int   hi_cnt = 0;
  int   lo_cnt = 0;
  initial begin
    lcd_response = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        lcd_response = 1'b0;
        hi_cnt = 0;
        lo_cnt = 0;
      end else if (lcd_command) begin
        hi_cnt++;
        lo_cnt = 0;
        if (hi_cnt >= 20 && !no_ack) lcd_response = 1'b1;
      end else begin
        hi_cnt = 0;
        lo_cnt++;
        if (lo_cnt >= 5) lcd_response = 1'b0;
      end
    end
  end

  // Handshake monitor: every rising command is matched against the expected queue.
  logic        prev_cmd = 1'b0;
  logic        active = 1'b0;
  logic        stable = 1'b1;
  logic [12:0] cap;
  logic [12:0] exp_cell;
  always @(negedge clk) begin
    if (rst_n) begin
      if (lcd_command && !prev_cmd) begin
        check("no_cmd_during_resp", 32'(lcd_response), 32'd0);
        cap    = {lcd_y, lcd_x, lcd_ascii};
        active = 1'b1;
        stable = 1'b1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_cmd: got idx %0d ascii 0x%0h, expected no command",
                   {lcd_y, lcd_x}, lcd_ascii);
        end else begin
          exp_cell = exp_q.pop_front();
          check("cmd_cell", 32'(cap), 32'(exp_cell));
        end
      end else if (active) begin
        if ({lcd_y, lcd_x, lcd_ascii} !== cap) stable = 1'b0;
        if (!lcd_command && !lcd_response) begin
          active = 1'b0;
          check("fields_stable", 32'(stable), 32'd1);
        end
      end
    end
    prev_cmd = lcd_command;
  end

  task automatic push_exp(input int idx, input logic [7:0] a);
    logic [4:0] i5;
    i5 = 5'(idx);
    exp_q.push_back({i5, a});
  endtask

  task automatic write_cell(input logic [3:0] x, input logic y, input logic [7:0] a);
    wr_en = 1'b1; wr_x = x; wr_y = y; wr_ascii = a;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(name, 32'(busy), 32'd0);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_cmd_rise(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (lcd_command) break;
    end
    check(name, 32'(lcd_command), 32'd1);
  endtask

  typedef struct {
    logic [3:0] x;
    logic       y;
    logic [7:0] ascii;
    logic [3:0] exp_x;
    logic       exp_y;
    logic [7:0] exp_ascii;
    int         exp_lat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int lat;
    int hi;

    vecs[0] = '{x: 4'd3,  y: 1'b1, ascii: 8'h41, exp_x: 4'd3,  exp_y: 1'b1, exp_ascii: 8'h41, exp_lat: 2};
    vecs[1] = '{x: 4'd0,  y: 1'b0, ascii: 8'h78, exp_x: 4'd0,  exp_y: 1'b0, exp_ascii: 8'h78, exp_lat: 2};
    vecs[2] = '{x: 4'd15, y: 1'b1, ascii: 8'h7e, exp_x: 4'd15, exp_y: 1'b1, exp_ascii: 8'h7e, exp_lat: 2};
    vecs[3] = '{x: 4'd7,  y: 1'b0, ascii: 8'h00, exp_x: 4'd7,  exp_y: 1'b0, exp_ascii: 8'h00, exp_lat: 2};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_lcd_command", 32'(lcd_command), 32'd0);
    check("rst_lcd_x", 32'(lcd_x), 32'd0);
    check("rst_lcd_y", 32'(lcd_y), 32'd0);
    check("rst_lcd_ascii", 32'(lcd_ascii), 32'h20);
    check("rst_timeout_error", 32'(timeout_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);

    // Blanking after reset: cells 0..31 as spaces
    for (int i = 0; i < 32; i++) push_exp(i, 8'h20);
    rst_n = 1'b1;
    wait_idle("blank_idle", 3000);
    check("blank_timeout_error", 32'(timeout_error), 32'd0);

    // Single-cell writes from the table
    for (int v = 0; v < 4; v++) begin
      push_exp(int'({vecs[v].exp_y, vecs[v].exp_x}), vecs[v].exp_ascii);
      wr_en = 1'b1; wr_x = vecs[v].x; wr_y = vecs[v].y; wr_ascii = vecs[v].ascii;
      lat = 0;
      for (int k = 1; k <= 50; k++) begin
        @(negedge clk);
        wr_en = 1'b0;
        lat = k;
        if (lcd_command) break;
      end
      check("wr_latency", 32'(lat), 32'(vecs[v].exp_lat));
      check("wr_lcd_x", 32'(lcd_x), 32'(vecs[v].exp_x));
      check("wr_lcd_y", 32'(lcd_y), 32'(vecs[v].exp_y));
      check("wr_lcd_ascii", 32'(lcd_ascii), 32'(vecs[v].exp_ascii));
      wait_idle("wr_idle", 200);
    end

    // Rewrite of cell 19 while its transfer is in flight
    push_exp(19, 8'h41);
    push_exp(19, 8'h42);
    write_cell(4'd3, 1'b1, 8'h41);
    wait_cmd_rise("inflight_rise", 50);
    repeat (3) @(negedge clk);
    write_cell(4'd3, 1'b1, 8'h42);
    wait_idle("inflight_idle", 300);

    // Round robin: cell 28 leaves rr_ptr at 29, then 30, 2, 5 become dirty
    push_exp(28, 8'h61);
    push_exp(30, 8'h62);
    push_exp(2, 8'h63);
    push_exp(5, 8'h64);
    write_cell(4'd12, 1'b1, 8'h61);
    wait_cmd_rise("rr_rise", 50);
    write_cell(4'd5, 1'b0, 8'h64);
    write_cell(4'd2, 1'b0, 8'h63);
    write_cell(4'd14, 1'b1, 8'h62);
    wait_idle("rr_idle", 500);

    // clear_req beats a same-cycle write; rr_ptr is 6 after cell 5
    for (int i = 6; i < 32; i++) push_exp(i, 8'h20);
    for (int i = 0; i < 6; i++) push_exp(i, 8'h20);
    clear_req = 1'b1;
    wr_en = 1'b1; wr_x = 4'd0; wr_y = 1'b0; wr_ascii = 8'h5a;
    @(negedge clk);
    clear_req = 1'b0;
    wr_en = 1'b0;
    wait_idle("clear_idle", 3000);

    // Timeout: LCD never acknowledges; cell 4 is retried
    no_ack = 1'b1;
    push_exp(4, 8'h54);
    push_exp(4, 8'h54);
    write_cell(4'd4, 1'b0, 8'h54);
    wait_cmd_rise("to_rise", 50);
    hi = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!lcd_command) break;
      hi++;
    end
    check("to_cmd_high_cycles", 32'(hi), 32'(TO));
    check("to_error_set", 32'(timeout_error), 32'd1);
    wait_cmd_rise("to_retry_rise", 50);
    check("to_retry_x", 32'(lcd_x), 32'd4);
    check("to_retry_ascii", 32'(lcd_ascii), 32'h54);
    no_ack = 1'b0;
    wait_idle("to_idle", 300);
    check("to_error_sticky", 32'(timeout_error), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
